// File: rtl/da_share_sched.sv
// da_share_sched: shares one 10-bit DA serializer between two producers with req/ack handshakes,
// a minimum start-to-start interval and a busy watchdog. Define DA_FIXED_PRIO_EN for strict producer-0 priority.
module da_share_sched #(
   parameter int unsigned DATA_W  = 10,
   parameter int unsigned MIN_GAP = 1000,
   parameter int unsigned BUSY_TO = 16
) (
   input  logic              CLK_50M,
   input  logic              RST,
   input  logic              REQ0,
   input  logic [DATA_W-1:0] DATA0,
   output logic              ACK0,
   input  logic              REQ1,
   input  logic [DATA_W-1:0] DATA1,
   output logic              ACK1,
   output logic [DATA_W-1:0] DA_DATA,
   output logic              DA_START,
   input  logic              DA_BUSY,
   output logic              GRANT_ID,
   output logic              ERR
);

   localparam int unsigned GAP_W = $clog2(MIN_GAP);
   localparam int unsigned TO_W  = $clog2(BUSY_TO + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP - 1);
   localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(BUSY_TO - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [GAP_W-1:0]  r_gap;
   logic [TO_W-1:0]   r_to;
   logic              r_start;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_gid;
   logic              r_err;
   logic [DATA_W-1:0] r_data;
   logic              w_issue;
   logic              w_err_nxt;
   logic              w_sel;

`ifdef DA_FIXED_PRIO_EN
   assign w_sel = ~REQ0;
`else
   logic r_ptr;

   assign w_sel = (REQ0 & REQ1) ? r_ptr : REQ1;

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         r_ptr <= 1'b0;
      end else if (w_issue) begin
         r_ptr <= ~w_sel;
      end
   end
`endif

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((REQ0 | REQ1) && (r_gap == GAP_MAX)) begin
               w_issue     = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (DA_BUSY) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_to == TO_MAX) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!DA_BUSY) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Both counters restart on the edge that enters ISSUE, so they read k during cycle start+k.
   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         r_gap <= GAP_MAX;
         r_to  <= '0;
      end else if (w_issue) begin
         r_gap <= '0;
         r_to  <= '0;
      end else begin
         if (r_gap != GAP_MAX) begin
            r_gap <= r_gap + GAP_W'(1);
         end
         if (r_to != TO_MAX) begin
            r_to <= r_to + TO_W'(1);
         end
      end
   end

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         r_start <= 1'b0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_err   <= 1'b0;
         r_gid   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_start <= w_issue;
         r_ack0  <= w_issue & ~w_sel;
         r_ack1  <= w_issue & w_sel;
         r_err   <= w_err_nxt;
         if (w_issue) begin
            r_gid  <= w_sel;
            r_data <= w_sel ? DATA1 : DATA0;
         end
      end
   end

   assign DA_START = r_start;
   assign ACK0     = r_ack0;
   assign ACK1     = r_ack1;
   assign ERR      = r_err;
   assign GRANT_ID = r_gid;
   assign DA_DATA  = r_data;

endmodule

// File: tb/tb_da_share_sched.sv
// Bench for da_share_sched: a cycle-level reference of the scheduling rules plus a simple serializer model.
// Compile with DA_FIXED_PRIO_EN defined to exercise the strict-priority build.
module tb_da_share_sched;

   localparam int DW = 10;
   localparam int MG = 20;
   localparam int BT = 16;
`ifdef DA_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk_50m = 1'b0;
   logic          rst     = 1'b0;
   logic          req0    = 1'b0;
   logic          req1    = 1'b0;
   logic [DW-1:0] data0   = '0;
   logic [DW-1:0] data1   = '0;
   logic          ack0, ack1, da_start, da_busy, grant_id, err;
   logic [DW-1:0] da_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int busy_len = 8;
   int busy_cnt = 0;
   int mode     = 0;

   // reference model state
   logic          e_start, e_ack0, e_ack1, e_err, e_gid;
   logic [DW-1:0] e_data;
   int            m_last, m_s, m_idle;
   logic          m_ptr, m_open, m_saw;

   // observations
   int   starts[$];
   int   gids[$];
   int   errs[$];
   int   fall_gap[$];
   int   last_fall = 0;
   logic prev_busy = 1'b0;
   logic busy_was  = 1'b0;

   da_share_sched #(
      .DATA_W (DW),
      .MIN_GAP(MG),
      .BUSY_TO(BT)
   ) dut (
      .CLK_50M (clk_50m),
      .RST     (rst),
      .REQ0    (req0),
      .DATA0   (data0),
      .ACK0    (ack0),
      .REQ1    (req1),
      .DATA1   (data1),
      .ACK1    (ack1),
      .DA_DATA (da_data),
      .DA_START(da_start),
      .DA_BUSY (da_busy),
      .GRANT_ID(grant_id),
      .ERR     (err)
   );

   always #10 clk_50m = ~clk_50m;

   always @(posedge clk_50m) cyc <= cyc + 1;

   // Serializer: busy for busy_len cycles starting the cycle after DA_START; busy_len 0 never answers.
   always @(posedge clk_50m or posedge rst) begin
      if (rst) busy_cnt <= 0;
      else if (da_start && busy_len > 0) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign da_busy = (busy_cnt != 0);

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      e_start = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0; e_err = 1'b0; e_gid = 1'b0; e_data = '0;
      m_last = -100000; m_idle = -100000; m_s = 0;
      m_ptr = 1'b0; m_open = 1'b0; m_saw = 1'b0;
   endtask

   // Predicts the outputs of cycle cyc+1 from the inputs of cycle cyc.
   task automatic model_next();
      logic sel;
      e_start = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0; e_err = 1'b0;
      if (m_open) begin
         if (cyc > m_s) begin
            if (da_busy) m_saw = 1'b1;
            else if (m_saw) begin
               m_open = 1'b0; m_idle = cyc + 1;
            end else if (cyc - m_s >= BT - 1) begin
               m_open = 1'b0; m_idle = cyc + 1; e_err = 1'b1;
            end
         end
      end else if (cyc >= m_idle && cyc - m_last >= MG - 1 && (req0 || req1)) begin
         if (req0 && req1) sel = FIXED ? 1'b0 : m_ptr;
         else sel = req1;
         e_start = 1'b1;
         e_ack0  = ~sel;
         e_ack1  = sel;
         e_gid   = sel;
         e_data  = sel ? data1 : data0;
         m_ptr   = ~sel;
         m_last  = cyc + 1;
         m_s     = cyc + 1;
         m_open  = 1'b1;
         m_saw   = 1'b0;
      end
   endtask

   task automatic tick_check();
      @(negedge clk_50m);
      check_eq("DA_START", da_start, e_start);
      check_eq("ACK0", ack0, e_ack0);
      check_eq("ACK1", ack1, e_ack1);
      check_eq("ERR", err, e_err);
      check_eq("GRANT_ID", grant_id, e_gid);
      check_eq("DA_DATA", da_data, e_data);
      if (prev_busy && !da_busy) last_fall = cyc;
      busy_was  = prev_busy;
      prev_busy = da_busy;
      if (da_start) begin
         starts.push_back(cyc);
         gids.push_back(int'(grant_id));
         fall_gap.push_back(cyc - last_fall);
      end
      if (err) errs.push_back(cyc);
   endtask

   task automatic tick_drive();
      case (mode)
         1: begin req0 = 1'b1; req1 = 1'b1; data0 = DW'($urandom); data1 = DW'($urandom); end
         2: begin req0 = 1'b1; req1 = 1'b0; data0 = DW'($urandom_range(1, 1023)); end
         3: begin req0 = 1'b0; req1 = 1'b1; data1 = DW'($urandom); end
         4: begin
            req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
            data0 = DW'($urandom); data1 = DW'($urandom);
         end
         5: begin req0 = 1'b0; req1 = da_busy && busy_was; data1 = DW'($urandom); end
         default: begin req0 = 1'b0; req1 = 1'b0; end
      endcase
      model_next();
   endtask

   task automatic run(input int n);
      repeat (n) begin
         tick_check();
         tick_drive();
      end
   endtask

   task automatic until_start(input int limit, input string tag);
      int n = 0;
      tick_check();
      while (!da_start && n < limit) begin
         tick_drive();
         tick_check();
         n++;
      end
      check_eq(tag, da_start, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int s;
      int found;
      model_reset();
      #1 rst = 1'b1;
      repeat (2) @(negedge clk_50m);
      check_eq("RST_DA_START", da_start, 0);
      check_eq("RST_ACK0", ack0, 0);
      check_eq("RST_ACK1", ack1, 0);
      check_eq("RST_ERR", err, 0);
      check_eq("RST_GRANT_ID", grant_id, 0);
      check_eq("RST_DA_DATA", da_data, 0);

      // single request straight out of reset
      rst = 1'b0; req0 = 1'b1; req1 = 1'b0; data0 = 10'h155; mode = 0;
      model_next();
      tick_check();
      check_eq("SINGLE_START", da_start, 1);
      check_eq("SINGLE_ACK0", ack0, 1);
      check_eq("SINGLE_ACK1", ack1, 0);
      check_eq("SINGLE_DATA", da_data, 10'h155);
      check_eq("SINGLE_GID", grant_id, 0);
      tick_drive();

      // both producers held, short frames
      busy_len = 8; mode = 1;
      run(10);
      base = starts.size();
      run(100);
      check_eq("RR_COUNT", starts.size() > base + 3, 1);
      for (int i = base + 1; i < base + 4 && i < starts.size(); i++) begin
         check_eq("RR_SPACING", starts[i] - starts[i-1], MG);
         check_eq("RR_GRANT", gids[i], FIXED ? 0 : (gids[i-1] ^ 1));
      end

      // frames longer than the gap
      busy_len = 30; mode = 2;
      base = starts.size();
      run(160);
      check_eq("LONG_COUNT", starts.size() > base + 3, 1);
      for (int i = base + 2; i < base + 4 && i < starts.size(); i++) begin
         check_eq("LONG_FALL_TO_START", fall_gap[i], 2);
         check_eq("LONG_SPACING_MIN", starts[i] - starts[i-1] >= MG, 1);
      end

      // serializer never answers
      busy_len = 0;
      base = starts.size();
      run(100);
      check_eq("TO_COUNT", starts.size() > base + 2, 1);
      if (starts.size() > base + 2) begin
         s = starts[base+1];
         found = 0;
         foreach (errs[j]) if (errs[j] == s + BT) found = 1;
         check_eq("TO_ERR_AT_BUSY_TO", found, 1);
         check_eq("TO_NEXT_START", starts[base+2] - s, MG);
      end

      // REQ1 only while the frame is shifting
      busy_len = 8; mode = 2;
      until_start(200, "WD_FIRST_START");
      mode = 5;
      tick_drive();
      base = starts.size();
      run(40);
      check_eq("WD_NO_EXTRA_START", starts.size() - base, 0);

      // reset in the middle of a long frame
      busy_len = 30; mode = 2;
      until_start(200, "RM_FIRST_START");
      mode = 0;
      tick_drive();
      run(9);
      #3 rst = 1'b1;
      #1;
      check_eq("RM_DA_START", da_start, 0);
      check_eq("RM_ACK0", ack0, 0);
      check_eq("RM_ACK1", ack1, 0);
      check_eq("RM_ERR", err, 0);
      check_eq("RM_GRANT_ID", grant_id, 0);
      check_eq("RM_DA_DATA", da_data, 0);
      model_reset();
      tick_check();
      rst = 1'b0; mode = 3;
      tick_drive();
      tick_check();
      check_eq("RM_REQ1_START", da_start, 1);
      check_eq("RM_REQ1_GID", grant_id, 1);
      mode = 0;
      tick_drive();
      run(40);

      // randomized traffic and serializer behaviour
      for (int blk = 0; blk < 40; blk++) begin
         busy_len = $urandom_range(0, 40);
         mode = $urandom_range(1, 4);
         run(60);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
